// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   8-bit UART transmit serializer with optional odd/even parity and one or
//   two stop bits. Accepts one byte per wr_en strobe while idle, shifts it out
//   LSB first on tx, and holds tx_busy for exactly one frame. tx_done pulses
//   for one cycle as tx_busy falls, which the upstream sequencer uses to
//   advance to its next byte.
//
// Parameters
//   FREQ_CLKIN  input clock frequency, Hz
//   BAUD_RATE   line rate, bit/s
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//
// Ports
//   clk      in   system clock, posedge
//   rst      in   synchronous reset, active-high (wins over wr_en)
//   data_in  in   byte to transmit, captured on accept
//   wr_en    in   write strobe, honoured only while tx_busy is low
//   tx       out  serial line, idle high, registered
//   tx_busy  out  registered, high for the whole frame
//   tx_done  out  one-cycle pulse in the cycle tx_busy falls
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int unsigned FREQ_CLKIN = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_DIV = FREQ_CLKIN / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam bit               HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shreg, shreg_next;
  logic             par_bit, par_bit_next;
  logic             tx_next, busy_next, done_next;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  // State and all outputs are registered together; the combinational process
  // below computes what tx/tx_busy/tx_done must be in the state being entered,
  // so no input reaches an output without passing through a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      par_bit  <= par_bit_next;
      tx       <= tx_next;
      tx_busy  <= busy_next;
      tx_done  <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    par_bit_next  = par_bit;
    tx_next       = tx;
    busy_next     = tx_busy;
    done_next     = 1'b0;

    unique case (state)
      S_IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        busy_next     = 1'b0;
        if (wr_en) begin
          state_next    = S_START;
          shreg_next    = data_in;
          // Parity is fixed at accept time, so later data_in changes and the
          // shifting of shreg cannot disturb it.
          par_bit_next  = (^data_in) ^ PAR_ODD;
          bit_idx_next  = '0;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
          tx_next      = shreg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
            if (HAS_PAR) begin
              state_next = S_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // The bit now on the line is shreg[0]; the next one is shreg[1]
            // and becomes shreg[0] after this shift.
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = {1'b0, shreg[7:1]};
            tx_next      = shreg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_next   = S_STOP;
          bit_idx_next = '0;
          tx_next      = 1'b1;
        end
      end

      S_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            state_next   = S_IDLE;
            bit_idx_next = '0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end

      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        tx_next       = 1'b1;
        busy_next     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four serializer instances (BAUD_DIV = 16) covering no parity, odd parity,
//   even parity and two stop bits. Each transmitted frame is compared cycle by
//   cycle against a waveform built from the byte: start bit, 8 data bits LSB
//   first, optional parity bit, stop bits, each held for 16 cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int DIV = 16;
  localparam int PAR_OF  [4] = '{0, 1, 2, 0};
  localparam int STOP_OF [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic [3:0] rst_v;
  logic [3:0] wr_v;
  logic [7:0] din_v [4];
  logic [3:0] tx_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.FREQ_CLKIN(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
    .clk(clk), .rst(rst_v[0]), .data_in(din_v[0]), .wr_en(wr_v[0]),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_serializer #(.FREQ_CLKIN(16), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1)) u_p1s1 (
    .clk(clk), .rst(rst_v[1]), .data_in(din_v[1]), .wr_en(wr_v[1]),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_serializer #(.FREQ_CLKIN(16), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(1)) u_p2s1 (
    .clk(clk), .rst(rst_v[2]), .data_in(din_v[2]), .wr_en(wr_v[2]),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_serializer #(.FREQ_CLKIN(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(2)) u_p0s2 (
    .clk(clk), .rst(rst_v[3]), .data_in(din_v[3]), .wr_en(wr_v[3]),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Line levels of one frame, one entry per bit period.
  task automatic frame_bits(input int k, input logic [7:0] b, output bit q[$]);
    int ones;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    ones = $countones(b);
    if (PAR_OF[k] == 1) q.push_back((ones % 2) == 0);
    if (PAR_OF[k] == 2) q.push_back((ones % 2) == 1);
    for (int i = 0; i < STOP_OF[k]; i++) q.push_back(1'b1);
  endtask

  task automatic idle_check(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("idle_tx[%0d]", k),   tx_v[k],   1);
      check_eq($sformatf("idle_busy[%0d]", k), busy_v[k], 0);
      check_eq($sformatf("idle_done[%0d]", k), done_v[k], 0);
    end
  endtask

  // Called with inputs settled after an edge; presents the byte, lets the next
  // edge accept it and follows the frame to the tx_done cycle (or to the reset
  // when rst_at >= 0). inj >= 0 raises wr_en with a foreign byte mid-frame.
  task automatic send_frame(input int k, input logic [7:0] b, input bit hold,
                            input int inj, input int rst_at);
    bit q[$];
    int f;
    frame_bits(k, b, q);
    f = q.size() * DIV;
    din_v[k] = b;
    wr_v[k]  = 1'b1;
    @(posedge clk); #1;
    if (!hold) wr_v[k] = 1'b0;
    din_v[k] = 8'($urandom);
    for (int c = 0; c < f; c++) begin
      check_eq($sformatf("tx[%0d] b=%02h c=%0d", k, b, c), tx_v[k], q[c / DIV]);
      check_eq($sformatf("busy[%0d] b=%02h c=%0d", k, b, c), busy_v[k], 1);
      check_eq($sformatf("done[%0d] b=%02h c=%0d", k, b, c), done_v[k], 0);
      if (c == inj) begin
        wr_v[k]  = 1'b1;
        din_v[k] = 8'h55;
      end else if (!hold && inj >= 0 && c == inj + 1) begin
        wr_v[k] = 1'b0;
      end
      if (c == rst_at) begin
        rst_v[k] = 1'b1;
        @(posedge clk); #1;
        check_eq($sformatf("rst_tx[%0d]", k),   tx_v[k],   1);
        check_eq($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
        check_eq($sformatf("rst_done[%0d]", k), done_v[k], 0);
        rst_v[k] = 1'b0;
        wr_v[k]  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_eq($sformatf("end_tx[%0d] b=%02h", k, b),   tx_v[k],   1);
    check_eq($sformatf("end_busy[%0d] b=%02h", k, b), busy_v[k], 0);
    check_eq($sformatf("end_done[%0d] b=%02h", k, b), done_v[k], 1);
  endtask

  initial begin
    rst_v = '1;
    wr_v  = '0;
    for (int i = 0; i < 4; i++) din_v[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;

    // Reset with a pending write: reset wins, nothing is sent.
    wr_v[0]  = 1'b1;
    din_v[0] = 8'hFF;
    @(posedge clk); #1;
    check_eq("reset_tx",   tx_v[0],   1);
    check_eq("reset_busy", busy_v[0], 0);
    check_eq("reset_done", done_v[0], 0);
    rst_v = '0;
    wr_v  = '0;
    idle_check(0, 3);

    // Plain frame, no parity.
    send_frame(0, 8'h48, 1'b0, -1, -1);
    idle_check(0, 2);

    // Odd and even parity on the same byte.
    send_frame(2, 8'h07, 1'b0, -1, -1);
    idle_check(2, 2);
    send_frame(1, 8'h07, 1'b0, -1, -1);
    idle_check(1, 2);

    // Two stop bits, wr_en held high: back-to-back frames.
    send_frame(3, 8'hA5, 1'b1, -1, -1);
    send_frame(3, 8'h3C, 1'b1, -1, -1);
    wr_v[3] = 1'b0;
    idle_check(3, 2);

    // Write during a frame is ignored.
    send_frame(0, 8'h0F, 1'b0, 40, -1);
    idle_check(0, 2);

    // Reset mid-frame, then a clean frame.
    send_frame(0, 8'hC3, 1'b0, -1, 70);
    idle_check(0, 3);
    send_frame(0, 8'h9A, 1'b0, -1, -1);
    idle_check(0, 1);

    // Random bytes, instances, ignored writes and spacing.
    for (int r = 0; r < 14; r++) begin
      int k;
      int inj;
      logic [7:0] b;
      k   = int'($urandom_range(0, 3));
      b   = 8'($urandom);
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 150)) : -1;
      send_frame(k, b, 1'b0, inj, -1);
      idle_check(k, int'($urandom_range(1, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
